// File: rtl/ex_alu_branch_unit_if.sv
// ----------------------------------------------------------------------------
// ex_alu_branch_unit_if
// Bundles the execute-stage inputs and the registered EX/MEM results.
//   stall       : 1 = hold the EX/MEM output registers
//   rs1_data    : register source 1 value
//   rs2_data    : register source 2 value
//   imm         : sign-extended immediate
//   pc          : PC of the instruction in EX
//   rs1mux_sel  : operand A select (0 rs1_data, 1 imm)
//   rs2mux_sel  : operand B select (0 rs2_data, 1 imm, 2 constant 4, 3 zero)
//   aluop       : ALU operation
//   brop        : branch compare (RISC-V funct3)
//   br_enable   : conditional branch
//   jal_enable  : JAL
//   jalr_enable : JALR
//   rd_data     : registered ALU result
//   jmp_tgt     : registered jump/branch target
//   pcmux_sel   : registered PC select (1 = take jmp_tgt)
// master = upstream pipeline driver, slave = execute unit.
// ----------------------------------------------------------------------------
interface ex_alu_branch_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic            rs1mux_sel;
  logic [1:0]      rs2mux_sel;
  logic [3:0]      aluop;
  logic [2:0]      brop;
  logic            br_enable;
  logic            jal_enable;
  logic            jalr_enable;
  logic [XLEN-1:0] rd_data;
  logic [XLEN-1:0] jmp_tgt;
  logic            pcmux_sel;

  modport master (
    output stall, rs1_data, rs2_data, imm, pc, rs1mux_sel, rs2mux_sel,
           aluop, brop, br_enable, jal_enable, jalr_enable,
    input  rd_data, jmp_tgt, pcmux_sel
  );

  modport slave (
    input  stall, rs1_data, rs2_data, imm, pc, rs1mux_sel, rs2mux_sel,
           aluop, brop, br_enable, jal_enable, jalr_enable,
    output rd_data, jmp_tgt, pcmux_sel
  );
endinterface

// File: rtl/ex_alu_branch_unit.sv
// ----------------------------------------------------------------------------
// ex_alu_branch_unit
// RV32I execute stage: operand selection, ALU, branch compare and jump/branch
// target resolution, with all results registered at the EX/MEM boundary.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears all outputs (beats stall)
//   bus   : ex_alu_branch_unit_if.slave carrying the EX inputs and the
//           registered rd_data / jmp_tgt / pcmux_sel outputs
// Results appear one clock after the inputs; stall freezes the outputs.
// ----------------------------------------------------------------------------
module ex_alu_branch_unit #(
  parameter int XLEN = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  ex_alu_branch_unit_if.slave  bus
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ZERO_C = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONE_C  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] FOUR_C = {{(XLEN-3){1'b0}}, 3'b100};

  logic [XLEN-1:0] op_a_s;
  logic [XLEN-1:0] op_b_s;
  logic [SHW-1:0]  sh_s;
  logic [XLEN-1:0] alu_s;
  logic            br_taken_s;
  logic [XLEN-1:0] tgt_s;
  logic            sel_s;

  logic [XLEN-1:0] rd_data_r;
  logic [XLEN-1:0] jmp_tgt_r;
  logic            pcmux_sel_r;

  // Operand A/B selection and shift amount extraction
  always_comb begin
    op_a_s = bus.rs1_data;
    op_b_s = bus.rs2_data;
    if (bus.rs1mux_sel) begin
      op_a_s = bus.imm;
    end else begin
      op_a_s = bus.rs1_data;
    end
    case (bus.rs2mux_sel)
      2'd0:    op_b_s = bus.rs2_data;
      2'd1:    op_b_s = bus.imm;
      2'd2:    op_b_s = FOUR_C;
      2'd3:    op_b_s = ZERO_C;
      default: op_b_s = ZERO_C;
    endcase
    sh_s = op_b_s[SHW-1:0];
  end

  // ALU operation decode; unused encodings return zero
  always_comb begin
    alu_s = ZERO_C;
    case (bus.aluop)
      4'd0:    alu_s = op_a_s + op_b_s;
      4'd1:    alu_s = op_a_s - op_b_s;
      4'd2:    alu_s = op_a_s << sh_s;
      4'd3:    alu_s = ($signed(op_a_s) < $signed(op_b_s)) ? ONE_C : ZERO_C;
      4'd4:    alu_s = (op_a_s < op_b_s) ? ONE_C : ZERO_C;
      4'd5:    alu_s = op_a_s ^ op_b_s;
      4'd6:    alu_s = op_a_s >> sh_s;
      4'd7:    alu_s = $unsigned($signed(op_a_s) >>> sh_s);
      4'd8:    alu_s = op_a_s | op_b_s;
      4'd9:    alu_s = op_a_s & op_b_s;
      default: alu_s = ZERO_C;
    endcase
  end

  // Branch compare always uses the raw register values, not the muxed operands
  always_comb begin
    br_taken_s = 1'b0;
    case (bus.brop)
      3'b000:  br_taken_s = (bus.rs1_data == bus.rs2_data);
      3'b001:  br_taken_s = (bus.rs1_data != bus.rs2_data);
      3'b100:  br_taken_s = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
      3'b101:  br_taken_s = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
      3'b110:  br_taken_s = (bus.rs1_data <  bus.rs2_data);
      3'b111:  br_taken_s = (bus.rs1_data >= bus.rs2_data);
      default: br_taken_s = 1'b0;
    endcase
  end

  // Target and PC select with priority jalr > jal > branch
  always_comb begin
    tgt_s = bus.pc + bus.imm;
    sel_s = 1'b0;
    if (bus.jalr_enable) begin
      // JALR clears bit 0 of the computed address
      tgt_s = (bus.rs1_data + bus.imm) & ~ONE_C;
      sel_s = 1'b1;
    end else if (bus.jal_enable) begin
      tgt_s = bus.pc + bus.imm;
      sel_s = 1'b1;
    end else if (bus.br_enable) begin
      tgt_s = bus.pc + bus.imm;
      sel_s = br_taken_s;
    end else begin
      tgt_s = bus.pc + bus.imm;
      sel_s = 1'b0;
    end
  end

  // EX/MEM output registers: reset wins over stall, stall holds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_r   <= ZERO_C;
      jmp_tgt_r   <= ZERO_C;
      pcmux_sel_r <= 1'b0;
    end else if (!bus.stall) begin
      rd_data_r   <= alu_s;
      jmp_tgt_r   <= tgt_s;
      pcmux_sel_r <= sel_s;
    end else begin
      rd_data_r   <= rd_data_r;
      jmp_tgt_r   <= jmp_tgt_r;
      pcmux_sel_r <= pcmux_sel_r;
    end
  end

  assign bus.rd_data   = rd_data_r;
  assign bus.jmp_tgt   = jmp_tgt_r;
  assign bus.pcmux_sel = pcmux_sel_r;

endmodule

// File: tb/tb_ex_alu_branch_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_alu_branch_unit
// Self-checking bench: directed vector table, randomized stimulus against a
// behavioural reference model, and hand-written stall/reset sequences.
// ----------------------------------------------------------------------------
module tb_ex_alu_branch_unit;

  logic clk;
  logic rst_n;

  ex_alu_branch_unit_if #(.XLEN(32)) bus ();

  ex_alu_branch_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        s1;
    logic [1:0]  s2;
    logic [3:0]  op;
    logic [2:0]  br;
    logic        be;
    logic        je;
    logic        jre;
    logic [31:0] exp_rd;
    logic [31:0] exp_tgt;
    logic        exp_sel;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_bad;

  function automatic vec_t mk(string name, logic [31:0] rs1, logic [31:0] rs2,
                              logic [31:0] imm, logic [31:0] pc, logic s1,
                              logic [1:0] s2, logic [3:0] op, logic [2:0] br,
                              logic be, logic je, logic jre,
                              logic [31:0] exp_rd, logic [31:0] exp_tgt,
                              logic exp_sel);
    vec_t v;
    v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
    v.s1 = s1; v.s2 = s2; v.op = op; v.br = br;
    v.be = be; v.je = je; v.jre = jre;
    v.exp_rd = exp_rd; v.exp_tgt = exp_tgt; v.exp_sel = exp_sel;
    return v;
  endfunction

  // Reference model: signed order obtained by flipping the sign bit
  function automatic logic slt_ref(logic [31:0] a, logic [31:0] b);
    return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
  endfunction

  function automatic logic [31:0] alu_ref(logic [3:0] op, logic [31:0] a,
                                          logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a + (~b) + 32'd1;
      4'd2:    return a * (32'd1 << sh);
      4'd3:    return slt_ref(a, b) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a / (32'd1 << sh);
      4'd7:    return a[31] ? ~((~a) / (32'd1 << sh)) : a / (32'd1 << sh);
      4'd8:    return a | b;
      4'd9:    return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic vec_t model(vec_t v);
    vec_t r;
    logic [31:0] a;
    logic [31:0] b;
    logic taken;
    r = v;
    a = v.s1 ? v.imm : v.rs1;
    case (v.s2)
      2'd0:    b = v.rs2;
      2'd1:    b = v.imm;
      2'd2:    b = 32'd4;
      default: b = 32'd0;
    endcase
    r.exp_rd = alu_ref(v.op, a, b);
    case (v.br)
      3'b000:  taken = (v.rs1 == v.rs2);
      3'b001:  taken = (v.rs1 != v.rs2);
      3'b100:  taken = slt_ref(v.rs1, v.rs2);
      3'b101:  taken = !slt_ref(v.rs1, v.rs2);
      3'b110:  taken = (v.rs1 < v.rs2);
      3'b111:  taken = !(v.rs1 < v.rs2);
      default: taken = 1'b0;
    endcase
    if (v.jre) begin
      r.exp_tgt = (v.rs1 + v.imm) & 32'hFFFF_FFFE;
      r.exp_sel = 1'b1;
    end else begin
      r.exp_tgt = v.pc + v.imm;
      r.exp_sel = v.je ? 1'b1 : (v.be ? taken : 1'b0);
    end
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.rs1_data    = v.rs1;
    bus.rs2_data    = v.rs2;
    bus.imm         = v.imm;
    bus.pc          = v.pc;
    bus.rs1mux_sel  = v.s1;
    bus.rs2mux_sel  = v.s2;
    bus.aluop       = v.op;
    bus.brop        = v.br;
    bus.br_enable   = v.be;
    bus.jal_enable  = v.je;
    bus.jalr_enable = v.jre;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(string name, logic [31:0] rd, logic [31:0] tgt,
                         logic sel);
    chk({name, ".rd"}, bus.rd_data, rd);
    chk({name, ".tgt"}, bus.jmp_tgt, tgt);
    chk({name, ".sel"}, {31'd0, bus.pcmux_sel}, {31'd0, sel});
  endtask

  initial begin
    vec_t v;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    drive(mk("idle", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 4'd0, 3'b000,
             1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0));

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      step();
      chk_out("reset", 32'd0, 32'd0, 1'b0);
    end
    rst_n = 1'b1;

    // Directed vector table: name rs1 rs2 imm pc s1 s2 op br be je jre | rd tgt sel
    vecs.push_back(mk("add5_7",  32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 2'd0, 4'd0, 3'b010, 1'b0, 1'b0, 1'b0, 32'd12, 32'd0, 1'b0));
    vecs.push_back(mk("sub",  32'hFFFF_FFF0, 32'd4, 32'd0, 32'd0, 1'b0, 2'd0, 4'd1, 3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFEC, 32'd0, 1'b0));
    vecs.push_back(mk("slt",  32'hFFFF_FFF0, 32'd4, 32'd0, 32'd0, 1'b0, 2'd0, 4'd3, 3'b010, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0, 1'b0));
    vecs.push_back(mk("sltu", 32'hFFFF_FFF0, 32'd4, 32'd0, 32'd0, 1'b0, 2'd0, 4'd4, 3'b010, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0));
    vecs.push_back(mk("sra",  32'hFFFF_FFF0, 32'd4, 32'd0, 32'd0, 1'b0, 2'd0, 4'd7, 3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0));
    vecs.push_back(mk("srl",  32'hFFFF_FFF0, 32'd4, 32'd0, 32'd0, 1'b0, 2'd0, 4'd6, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0FFF_FFFF, 32'd0, 1'b0));
    vecs.push_back(mk("sll",  32'hFFFF_FFF0, 32'd4, 32'd0, 32'd0, 1'b0, 2'd0, 4'd2, 3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FF00, 32'd0, 1'b0));
    vecs.push_back(mk("sra24", 32'hFFFF_FFF0, 32'h24, 32'd0, 32'd0, 1'b0, 2'd0, 4'd7, 3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0));
    vecs.push_back(mk("srl24", 32'hFFFF_FFF0, 32'h24, 32'd0, 32'd0, 1'b0, 2'd0, 4'd6, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0FFF_FFFF, 32'd0, 1'b0));
    vecs.push_back(mk("sll24", 32'hFFFF_FFF0, 32'h24, 32'd0, 32'd0, 1'b0, 2'd0, 4'd2, 3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FF00, 32'd0, 1'b0));
    vecs.push_back(mk("xor",  32'hFFFF_FFF0, 32'd4, 32'd0, 32'd0, 1'b0, 2'd0, 4'd5, 3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF4, 32'd0, 1'b0));
    vecs.push_back(mk("or",   32'hFFFF_FFF0, 32'd4, 32'd0, 32'd0, 1'b0, 2'd0, 4'd8, 3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF4, 32'd0, 1'b0));
    vecs.push_back(mk("and",  32'hFFFF_FFF0, 32'd4, 32'd0, 32'd0, 1'b0, 2'd0, 4'd9, 3'b010, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0));
    vecs.push_back(mk("op12", 32'hFFFF_FFF0, 32'd4, 32'd0, 32'd0, 1'b0, 2'd0, 4'd12, 3'b010, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0));
    vecs.push_back(mk("mux_imm_4", 32'd77, 32'd55, 32'h100, 32'd0, 1'b1, 2'd2, 4'd0, 3'b010, 1'b0, 1'b0, 1'b0, 32'h104, 32'h100, 1'b0));
    vecs.push_back(mk("mux_zero", 32'd9, 32'd5, 32'd0, 32'd0, 1'b0, 2'd3, 4'd0, 3'b010, 1'b0, 1'b0, 1'b0, 32'd9, 32'd0, 1'b0));
    vecs.push_back(mk("mux_b_imm", 32'd10, 32'd99, 32'd3, 32'd0, 1'b0, 2'd1, 4'd1, 3'b010, 1'b0, 1'b0, 1'b0, 32'd7, 32'd3, 1'b0));
    vecs.push_back(mk("beq",  32'd3, 32'd3, 32'h20, 32'h1000, 1'b0, 2'd0, 4'd0, 3'b000, 1'b1, 1'b0, 1'b0, 32'd6, 32'h1020, 1'b1));
    vecs.push_back(mk("bne",  32'd3, 32'd3, 32'h20, 32'h1000, 1'b0, 2'd0, 4'd0, 3'b001, 1'b1, 1'b0, 1'b0, 32'd6, 32'h1020, 1'b0));
    vecs.push_back(mk("blt",  32'hFFFF_FFFF, 32'd1, 32'h20, 32'h1000, 1'b0, 2'd0, 4'd0, 3'b100, 1'b1, 1'b0, 1'b0, 32'd0, 32'h1020, 1'b1));
    vecs.push_back(mk("bltu", 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h1000, 1'b0, 2'd0, 4'd0, 3'b110, 1'b1, 1'b0, 1'b0, 32'd0, 32'h1020, 1'b0));
    vecs.push_back(mk("bge",  32'hFFFF_FFFF, 32'd1, 32'h20, 32'h1000, 1'b0, 2'd0, 4'd0, 3'b101, 1'b1, 1'b0, 1'b0, 32'd0, 32'h1020, 1'b0));
    vecs.push_back(mk("bgeu", 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h1000, 1'b0, 2'd0, 4'd0, 3'b111, 1'b1, 1'b0, 1'b0, 32'd0, 32'h1020, 1'b1));
    vecs.push_back(mk("br010", 32'd3, 32'd3, 32'h20, 32'h1000, 1'b0, 2'd0, 4'd0, 3'b010, 1'b1, 1'b0, 1'b0, 32'd6, 32'h1020, 1'b0));
    vecs.push_back(mk("beq_noen", 32'd3, 32'd3, 32'h20, 32'h1000, 1'b0, 2'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd6, 32'h1020, 1'b0));
    vecs.push_back(mk("jal",  32'd0, 32'd0, 32'hFFFF_FFF8, 32'h2000, 1'b0, 2'd0, 4'd0, 3'b010, 1'b0, 1'b1, 1'b0, 32'd0, 32'h1FF8, 1'b1));
    vecs.push_back(mk("jalr", 32'h3001, 32'd0, 32'h10, 32'h2000, 1'b0, 2'd0, 4'd0, 3'b010, 1'b0, 1'b0, 1'b1, 32'h3001, 32'h3010, 1'b1));
    vecs.push_back(mk("jal_jalr", 32'h3001, 32'd0, 32'h10, 32'h2000, 1'b0, 2'd0, 4'd0, 3'b010, 1'b0, 1'b1, 1'b1, 32'h3001, 32'h3010, 1'b1));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      step();
      chk_out(vecs[i].name, vecs[i].exp_rd, vecs[i].exp_tgt, vecs[i].exp_sel);
    end

    // Randomized stimulus checked against the reference model
    for (int i = 0; i < 400; i++) begin
      v.name = "rnd";
      v.rs1  = $urandom;
      v.rs2  = ($urandom_range(0, 3) == 0) ? v.rs1 : 32'($urandom);
      v.imm  = $urandom;
      v.pc   = $urandom;
      v.s1   = 1'($urandom_range(0, 1));
      v.s2   = 2'($urandom_range(0, 3));
      v.op   = 4'($urandom_range(0, 15));
      v.br   = 3'($urandom_range(0, 7));
      v.be   = 1'($urandom_range(0, 1));
      v.je   = ($urandom_range(0, 3) == 0);
      v.jre  = ($urandom_range(0, 3) == 0);
      v = model(v);
      drive(v);
      step();
      chk_out("rnd", v.exp_rd, v.exp_tgt, v.exp_sel);
    end

    // Stall holds the previous result, release loads the current inputs
    drive(mk("ld12", 32'd5, 32'd7, 32'h20, 32'h1000, 1'b0, 2'd0, 4'd0, 3'b000, 1'b1, 1'b0, 1'b0, 32'd12, 32'h1020, 1'b0));
    step();
    chk_out("ld12", 32'd12, 32'h1020, 1'b0);
    bus.stall = 1'b1;
    drive(mk("ld99", 32'd90, 32'd9, 32'h40, 32'h4000, 1'b0, 2'd0, 4'd0, 3'b001, 1'b1, 1'b0, 1'b0, 32'd99, 32'h4040, 1'b1));
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall_hold", 32'd12, 32'h1020, 1'b0);
    end
    bus.stall = 1'b0;
    step();
    chk_out("stall_release", 32'd99, 32'h4040, 1'b1);

    // Reset beats stall
    bus.stall = 1'b1;
    rst_n = 1'b0;
    step();
    chk_out("rst_over_stall", 32'd0, 32'd0, 1'b0);

    // First non-reset, non-stalled edge loads current inputs
    rst_n = 1'b1;
    bus.stall = 1'b0;
    step();
    chk_out("post_reset", 32'd99, 32'h4040, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
